pid_incr: RTL and testbench

Incremental PID update engine: consumes one error sample set e(k), e(k-1), e(k-2) per control period from the upstream error stage and produces the controller output u(k) = u(k-1) + Δu.
- Δu = Kp·(e0−e1) + Ki·e0 + Kd·(e0−2e1+e2).
- A single shared multiplier evaluates the three products sequentially over three cycles, then a fourth cycle accumulates, scales and saturates.
- Sits between the error stage and the plant/actuator interface.

---
 rtl/pid_pkg.sv | 43 ++++
 rtl/pid_sat.sv | 32 +++
 rtl/pid_incr.sv | 205 ++++++++++++++++++++
 tb/tb_pid_incr.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types, widths and operand helpers for the incremental PID engine.
package pid_pkg;

    // Update sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_P  = 3'd1,
        MUL_I  = 3'd2,
        MUL_D  = 3'd3,
        UPDATE = 3'd4
    } state_e;

    // Data, multiplier operand, product, accumulator and sum widths
    localparam int DW  = 32;
    localparam int OPW = 34;
    localparam int PW  = 66;
    localparam int AW  = 68;
    localparam int SW  = 69;

    // Default number of fractional bits in the gains
    localparam int FRAC_DEF = 16;

    // Sign-extend a data word to the multiplier operand width
    function automatic logic signed [OPW-1:0] sext_op(input logic signed [DW-1:0] v);
        return $signed({{(OPW-DW){v[DW-1]}}, v});
    endfunction

    // Proportional operand e0 - e1 (needs 33 bits, carried in 34)
    function automatic logic signed [OPW-1:0] p_operand(input logic signed [DW-1:0] e0,
                                                        input logic signed [DW-1:0] e1);
        return sext_op(e0) - sext_op(e1);
    endfunction

    // Derivative operand e0 - 2*e1 + e2; extremes are +/-(2^33 - 2), so 34 bits suffice
    function automatic logic signed [OPW-1:0] d_operand(input logic signed [DW-1:0] e0,
                                                        input logic signed [DW-1:0] e1,
                                                        input logic signed [DW-1:0] e2);
        logic signed [OPW-1:0] e1x2;
        e1x2 = sext_op(e1) <<< 1;
        return sext_op(e0) - e1x2 + sext_op(e2);
    endfunction

endpackage

// File: rtl/pid_sat.sv
// Combinational clamp of the wide u + delta sum into [UMIN, UMAX].
module pid_sat
    import pid_pkg::*;
#(
    parameter logic signed [DW-1:0] UMAX = 32'sh7FFF_FFFF,
    parameter logic signed [DW-1:0] UMIN = 32'sh8000_0000
) (
    input  logic signed [SW-1:0] sum_i,
    output logic signed [DW-1:0] val_o,
    output logic                 sat_o
);

    localparam logic signed [SW-1:0] UMAX_X = $signed({{(SW-DW){UMAX[DW-1]}}, UMAX});
    localparam logic signed [SW-1:0] UMIN_X = $signed({{(SW-DW){UMIN[DW-1]}}, UMIN});

    // Select the bound that was crossed, or pass the in-range sum through
    always_comb begin
        val_o = sum_i[DW-1:0];
        sat_o = 1'b0;
        if (sum_i > UMAX_X) begin
            val_o = UMAX;
            sat_o = 1'b1;
        end else if (sum_i < UMIN_X) begin
            val_o = UMIN;
            sat_o = 1'b1;
        end else begin
            val_o = sum_i[DW-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/pid_incr.sv
// Incremental PID update: u(k) = sat(u(k-1) + (Kp*(e0-e1) + Ki*e0 + Kd*(e0-2e1+e2)) >>> FRAC).
// One shared 34x32 multiplier is time-multiplexed over three cycles, a fourth
// cycle scales, adds and saturates.
module pid_incr
    import pid_pkg::*;
#(
    parameter int                   FRAC = FRAC_DEF,
    parameter logic signed [DW-1:0] UMAX = 32'sh7FFF_FFFF,
    parameter logic signed [DW-1:0] UMIN = 32'sh8000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 start,
    input  logic signed [DW-1:0] ek0,
    input  logic signed [DW-1:0] ek1,
    input  logic signed [DW-1:0] ek2,
    input  logic signed [DW-1:0] kp,
    input  logic signed [DW-1:0] ki,
    input  logic signed [DW-1:0] kd,
    output logic                 busy,
    output logic signed [DW-1:0] u,
    output logic                 u_valid,
    output logic                 u_sat
);

    state_e state_q, state_d;

    logic signed [DW-1:0] e0_q, e0_d;
    logic signed [DW-1:0] e1_q, e1_d;
    logic signed [DW-1:0] e2_q, e2_d;
    logic signed [DW-1:0] kp_q, kp_d;
    logic signed [DW-1:0] ki_q, ki_d;
    logic signed [DW-1:0] kd_q, kd_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] u_q, u_d;
    logic                 u_valid_q, u_valid_d;
    logic                 u_sat_q, u_sat_d;
    logic                 busy_q, busy_d;

    logic signed [OPW-1:0] op_a_s;
    logic signed [DW-1:0]  op_b_s;
    logic signed [PW-1:0]  prod_s;
    logic signed [AW-1:0]  prod_ext_s;
    logic signed [AW-1:0]  delta_s;
    logic signed [SW-1:0]  sum_s;
    logic signed [DW-1:0]  clamp_s;
    logic                  clamp_sat_s;

    // Operand mux feeding the single multiplier, steered by the current phase
    always_comb begin
        op_a_s = {OPW{1'b0}};
        op_b_s = {DW{1'b0}};
        case (state_q)
            MUL_P: begin
                op_a_s = p_operand(e0_q, e1_q);
                op_b_s = kp_q;
            end
            MUL_I: begin
                op_a_s = sext_op(e0_q);
                op_b_s = ki_q;
            end
            MUL_D: begin
                op_a_s = d_operand(e0_q, e1_q, e2_q);
                op_b_s = kd_q;
            end
            default: begin
                op_a_s = {OPW{1'b0}};
                op_b_s = {DW{1'b0}};
            end
        endcase
    end

    // The one multiplier: both operands widened to the full product width first
    assign prod_s     = $signed({{(PW-OPW){op_a_s[OPW-1]}}, op_a_s})
                      * $signed({{(PW-DW){op_b_s[DW-1]}}, op_b_s});
    assign prod_ext_s = $signed({{(AW-PW){prod_s[PW-1]}}, prod_s});

    // Scale back to integer units (floor) and form the wide candidate output
    assign delta_s = acc_q >>> FRAC;
    assign sum_s   = $signed({{(SW-DW){u_q[DW-1]}}, u_q}) + $signed({delta_s[AW-1], delta_s});

    pid_sat #(
        .UMAX (UMAX),
        .UMIN (UMIN)
    ) u_sat_blk (
        .sum_i (sum_s),
        .val_o (clamp_s),
        .sat_o (clamp_sat_s)
    );

    // Next-state logic of the update sequencer; clr wins over everything
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = MUL_P;
                    end else begin
                        state_d = IDLE;
                    end
                end
                MUL_P:   state_d = MUL_I;
                MUL_I:   state_d = MUL_D;
                MUL_D:   state_d = UPDATE;
                UPDATE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: operand capture, accumulation and output update
    always_comb begin
        e0_d      = e0_q;
        e1_d      = e1_q;
        e2_d      = e2_q;
        kp_d      = kp_q;
        ki_d      = ki_q;
        kd_d      = kd_q;
        acc_d     = acc_q;
        u_d       = u_q;
        u_sat_d   = u_sat_q;
        u_valid_d = 1'b0;
        if (clr) begin
            acc_d   = {AW{1'b0}};
            u_d     = {DW{1'b0}};
            u_sat_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        e0_d  = ek0;
                        e1_d  = ek1;
                        e2_d  = ek2;
                        kp_d  = kp;
                        ki_d  = ki;
                        kd_d  = kd;
                        acc_d = {AW{1'b0}};
                    end else begin
                        acc_d = acc_q;
                    end
                end
                MUL_P, MUL_I, MUL_D: begin
                    acc_d = acc_q + prod_ext_s;
                end
                UPDATE: begin
                    u_d       = clamp_s;
                    u_sat_d   = clamp_sat_s;
                    u_valid_d = 1'b1;
                end
                default: begin
                    acc_d = {AW{1'b0}};
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, accumulator and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q      <= {DW{1'b0}};
            e1_q      <= {DW{1'b0}};
            e2_q      <= {DW{1'b0}};
            kp_q      <= {DW{1'b0}};
            ki_q      <= {DW{1'b0}};
            kd_q      <= {DW{1'b0}};
            acc_q     <= {AW{1'b0}};
            u_q       <= {DW{1'b0}};
            u_valid_q <= 1'b0;
            u_sat_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            e0_q      <= e0_d;
            e1_q      <= e1_d;
            e2_q      <= e2_d;
            kp_q      <= kp_d;
            ki_q      <= ki_d;
            kd_q      <= kd_d;
            acc_q     <= acc_d;
            u_q       <= u_d;
            u_valid_q <= u_valid_d;
            u_sat_q   <= u_sat_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign u       = u_q;
    assign u_valid = u_valid_q;
    assign u_sat   = u_sat_q;

endmodule

// File: tb/tb_pid_incr.sv
// Directed bench for pid_incr with UMAX=1000, UMIN=-1000, FRAC=16.
module tb_pid_incr;

    logic               clk;
    logic               rst_n;
    logic               clr;
    logic               start;
    logic signed [31:0] ek0, ek1, ek2, kp, ki, kd;
    logic               busy;
    logic signed [31:0] u;
    logic               u_valid;
    logic               u_sat;

    int n_checks;
    int n_pass;

    pid_incr #(
        .FRAC (16),
        .UMAX (32'sd1000),
        .UMIN (-32'sd1000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .start   (start),
        .ek0     (ek0),
        .ek1     (ek1),
        .ek2     (ek2),
        .kp      (kp),
        .ki      (ki),
        .kd      (kd),
        .busy    (busy),
        .u       (u),
        .u_valid (u_valid),
        .u_sat   (u_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               pre_clr;
        logic signed [31:0] e0, e1, e2, gp, gi, gd;
        logic signed [31:0] exp_u;
        logic               exp_sat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // One full update: checks busy window, single u_valid pulse and the result.
    // Inputs are scrambled after the start cycle to show they were latched.
    task automatic run_update(input string tag, input logic signed [31:0] e0, e1, e2, gp, gi, gd,
                              input logic signed [31:0] exp_u, input logic exp_sat);
        int busy_cnt;
        int early_valid;
        busy_cnt = 0;
        early_valid = 0;
        @(negedge clk);
        ek0 = e0; ek1 = e1; ek2 = e2; kp = gp; ki = gi; kd = gd;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            ek0 = ~e0; ek1 = e2; ek2 = e1; kp = 32'sd12345; ki = -32'sd777; kd = 32'sd99999;
            if (busy) busy_cnt++;
            if (u_valid) early_valid++;
        end
        @(negedge clk);
        chk({tag, " busy_cycles"}, busy_cnt, 4);
        chk({tag, " early_valid"}, early_valid, 0);
        chk({tag, " u_valid"}, u_valid, 1);
        chk({tag, " busy_in_valid"}, busy, 0);
        chk({tag, " u"}, u, exp_u);
        chk({tag, " u_sat"}, u_sat, exp_sat);
        @(negedge clk);
        chk({tag, " u_valid_drop"}, u_valid, 0);
        chk({tag, " u_hold"}, u, exp_u);
    endtask

    initial begin
        int vcnt;
        logic signed [31:0] first_u;
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; clr = 1'b0; start = 1'b0;
        ek0 = 32'sd0; ek1 = 32'sd0; ek2 = 32'sd0; kp = 32'sd0; ki = 32'sd0; kd = 32'sd0;

        //              clr   e0            e1            e2            kp           ki          kd           u          sat
        vecs[0]  = '{1'b0, 32'sd100,     32'sd40,      32'sd0,       32'sd65536, 32'sd0,     32'sd0,      32'sd60,   1'b0};
        vecs[1]  = '{1'b1, 32'sd3,       32'sd0,       32'sd0,       32'sd0,     32'sd32768, 32'sd0,      32'sd1,    1'b0};
        vecs[2]  = '{1'b0, -32'sd3,      32'sd0,       32'sd0,       32'sd0,     32'sd32768, 32'sd0,      -32'sd1,   1'b0};
        vecs[3]  = '{1'b1, 32'sd10,      32'sd4,       32'sd1,       32'sd0,     32'sd0,     32'sd65536,  32'sd3,    1'b0};
        vecs[4]  = '{1'b0, 32'sd10,      32'sd4,       32'sd1,       32'sd65536, 32'sd65536, 32'sd65536,  32'sd22,   1'b0};
        vecs[5]  = '{1'b1, 32'sd990,     32'sd0,       32'sd0,       32'sd65536, 32'sd0,     32'sd0,      32'sd990,  1'b0};
        vecs[6]  = '{1'b0, 32'sd60,      32'sd0,       32'sd0,       32'sd65536, 32'sd0,     32'sd0,      32'sd1000, 1'b1};
        vecs[7]  = '{1'b0, -32'sd5,      32'sd0,       32'sd0,       32'sd65536, 32'sd0,     32'sd0,      32'sd995,  1'b0};
        vecs[8]  = '{1'b1, -32'sd990,    32'sd0,       32'sd0,       32'sd65536, 32'sd0,     32'sd0,      -32'sd990, 1'b0};
        vecs[9]  = '{1'b0, -32'sd60,     32'sd0,       32'sd0,       32'sd65536, 32'sd0,     32'sd0,      -32'sd1000,1'b1};
        vecs[10] = '{1'b0, 32'sd5,       32'sd0,       32'sd0,       32'sd65536, 32'sd0,     32'sd0,      -32'sd995, 1'b0};
        // Extreme P operand: (2^31-1) - (-2^31) = 2^32-1 -> clamps high
        vecs[11] = '{1'b0, 32'sh7FFFFFFF, 32'sh80000000, 32'sd0,     32'sd65536, 32'sd0,     32'sd0,      32'sd1000, 1'b1};
        // Extreme D operand -(2^33-2) times -1.0 -> +(2^33-2), still clamps high from u=1000
        vecs[12] = '{1'b0, 32'sh80000000, 32'sh7FFFFFFF, 32'sh80000000, 32'sd0,  32'sd0,     32'shFFFF0000, 32'sd1000, 1'b1};
        // Negative extreme P operand with gain 1.0 from u=1000 -> clamps low
        vecs[13] = '{1'b0, 32'sh80000000, 32'sh7FFFFFFF, 32'sd0,     32'sd65536, 32'sd0,     32'sd0,      -32'sd1000, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset u", u, 0);
        chk("reset u_valid", u_valid, 0);
        chk("reset u_sat", u_sat, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 14; v++) begin
            if (vecs[v].pre_clr) do_clear();
            run_update($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1, vecs[v].e2,
                       vecs[v].gp, vecs[v].gi, vecs[v].gd, vecs[v].exp_u, vecs[v].exp_sat);
        end

        // clr resets u and u_sat
        do_clear();
        chk("clr u", u, 0);
        chk("clr u_sat", u_sat, 0);

        // start held for 6 cycles: first update at i=4, second accepted on the valid cycle
        @(negedge clk);
        ek0 = 32'sd7; ek1 = 32'sd0; ek2 = 32'sd0; kp = 32'sd65536; ki = 32'sd0; kd = 32'sd0;
        start = 1'b1;
        vcnt = 0;
        first_u = 32'sd0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 5) start = 1'b0;
            if (u_valid) begin
                vcnt++;
                if (vcnt == 1) first_u = u;
                if (vcnt == 1) chk("hold first_valid_cycle", i, 4);
                if (vcnt == 2) chk("hold second_valid_cycle", i, 9);
            end
        end
        chk("hold valid_count", vcnt, 2);
        chk("hold first_u", first_u, 7);
        chk("hold final_u", u, 14);

        // start pulses while busy are ignored
        @(negedge clk);
        ek0 = 32'sd5;
        start = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 3) begin
                start = 1'b1;
                ek0 = 32'sd100;
            end else begin
                start = 1'b0;
            end
            if (u_valid) vcnt++;
        end
        chk("busy_start valid_count", vcnt, 1);
        chk("busy_start u", u, 19);

        // clr during MUL_I aborts the update
        @(negedge clk);
        ek0 = 32'sd5;
        start = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            clr = (i == 1);
            if (i == 2) begin
                chk("abort u", u, 0);
                chk("abort busy", busy, 0);
            end
            if (u_valid) vcnt++;
        end
        chk("abort valid_count", vcnt, 0);
        chk("abort u_hold", u, 0);

        // Saturate, then async reset during MUL_D
        run_update("presat", 32'sd2000, 32'sd0, 32'sd0, 32'sd65536, 32'sd0, 32'sd0, 32'sd1000, 1'b1);
        @(negedge clk);
        ek0 = 32'sd50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid u", u, 0);
        chk("rst_mid u_sat", u_sat, 0);
        chk("rst_mid u_valid", u_valid, 0);
        chk("rst_mid busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_update("post_rst", 32'sd8, 32'sd0, 32'sd0, 32'sd65536, 32'sd0, 32'sd0, 32'sd8, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
